sprite_layer_renderer: RTL and testbench

Draws one animated, positioned, integer-scaled sprite over a background pixel stream on the VGA pixel pipeline. Successor to the single-image full-screen stretch renderer: adds position, multi-frame sheets, power-of-two scaling, horizontal flip, transparency, and tear-free parameter latching. Sits between the background generator and the VGA controller. Drives an external synchronous sprite ROM and a combinational palette.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_delay_line.sv | 26 ++
 rtl/sprite_layer_renderer.sv | 174 +++++++++++++++++
 tb/tb_sprite_layer_renderer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer renderer.
// PIX_W is derived from the screen size, which gives 10 bits for 640x480.
package sprite_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PIX_W    = addr_width((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  typedef logic [3:0] colour_t;

  typedef struct packed {
    colour_t red;
    colour_t green;
    colour_t blue;
  } rgb_t;

  // Per-pixel side information carried alongside the ROM fetch.
  typedef struct packed {
    logic vis;
    logic hit;
    rgb_t bg;
  } align_t;

  typedef enum logic [1:0] {
    SRC_BLACK,
    SRC_BG,
    SRC_SPRITE
  } pix_src_e;

endpackage

// File: rtl/sprite_delay_line.sv
// Parametrised width/depth shift register with asynchronous active-low clear,
// used to keep the pixel side information aligned with the ROM pipeline.
module sprite_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sprite_layer_renderer.sv
// Positioned, animated, power-of-two scaled sprite composited over a background
// stream with 3-cycle latency. Optional macro SPRITE_PIXCOUNT_EN adds opaque_count.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned ROM_AW     = addr_width(SPR_W * SPR_H * FRAMES),
  parameter int unsigned FRAME_W    = addr_width(FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [PIX_W-1:0]   DrawX,
  input  logic [PIX_W-1:0]   DrawY,
  input  logic               blank,
  input  logic [PIX_W-1:0]   sprite_x,
  input  logic [PIX_W-1:0]   sprite_y,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               flip_h,
  input  logic               sprite_en,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_idx,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
`ifdef SPRITE_PIXCOUNT_EN
  ,
  output logic [12:0]        opaque_count
`endif
);

  localparam int unsigned XW    = addr_width(SPR_W);
  localparam int unsigned YW    = addr_width(SPR_H);
  localparam int unsigned EXT_W = SPR_W << SCALE_LOG2;
  localparam int unsigned EXT_H = SPR_H << SCALE_LOG2;

  logic [PIX_W-1:0]   sh_x;
  logic [PIX_W-1:0]   sh_y;
  logic [FRAME_W-1:0] sh_frame;
  logic               sh_flip;
  logic               sh_en;
  logic               armed;
  logic               origin;

  assign origin = (DrawX == '0) && (DrawY == '0);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_frame <= '0;
      sh_flip  <= 1'b0;
      sh_en    <= 1'b0;
      armed    <= 1'b0;
    end else if (origin) begin
      sh_x     <= sprite_x;
      sh_y     <= sprite_y;
      sh_frame <= frame_sel;
      sh_flip  <= flip_h;
      sh_en    <= sprite_en;
      armed    <= 1'b1;
    end
  end

  // Stage 0: sprite-relative coordinates; bit PIX_W is the borrow.
  logic [PIX_W:0]  dx;
  logic [PIX_W:0]  dy;
  logic            hit_s0;
  logic            vis_s0;
  logic [XW-1:0]   lx;
  logic [XW-1:0]   tex_x;
  logic [YW-1:0]   ly;

  assign dx = {1'b0, DrawX} - {1'b0, sh_x};
  assign dy = {1'b0, DrawY} - {1'b0, sh_y};

  assign hit_s0 = sh_en && !dx[PIX_W] && !dy[PIX_W]
                  && (dx < (PIX_W+1)'(EXT_W)) && (dy < (PIX_W+1)'(EXT_H));

  assign lx    = dx[SCALE_LOG2 +: XW];
  assign ly    = dy[SCALE_LOG2 +: YW];
  assign tex_x = sh_flip ? (XW'(SPR_W - 1) - lx) : lx;

  // The origin pixel itself is shown; everything before the first origin
  // after reset stays black.
  assign vis_s0 = blank && (armed || origin);

  // Address only moves on a hit so the ROM sees no toggling elsewhere.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
    end else if (hit_s0) begin
      rom_addr <= ROM_AW'({sh_frame, ly, tex_x});
    end
  end

  assign pal_idx = rom_q;

  // Two register stages here plus the output register give the 3-cycle match.
  align_t align_in;
  align_t align_d;

  assign align_in = '{vis: vis_s0, hit: hit_s0, bg: '{red: bg_red, green: bg_green, blue: bg_blue}};

  sprite_delay_line #(
    .WIDTH($bits(align_t)),
    .DEPTH(2)
  ) u_align (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (align_in),
    .q       (align_d)
  );

  // Stage 2: choose the source and register the final colour.
  pix_src_e src;
  rgb_t     pix_next;
  rgb_t     pix_q;

  always_comb begin
    src      = SRC_BLACK;
    pix_next = '0;
    if (align_d.vis) begin
      if (align_d.hit && (rom_q != IDX_W'(TRANSP_IDX))) src = SRC_SPRITE;
      else                                               src = SRC_BG;
    end
    case (src)
      SRC_SPRITE: pix_next = '{red: pal_red, green: pal_green, blue: pal_blue};
      SRC_BG:     pix_next = align_d.bg;
      default:    pix_next = '0;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) pix_q <= '0;
    else          pix_q <= pix_next;
  end

  assign red   = pix_q.red;
  assign green = pix_q.green;
  assign blue  = pix_q.blue;

`ifdef SPRITE_PIXCOUNT_EN
  logic [12:0] opaque_cnt;
  logic        draw_sprite;

  assign draw_sprite = (src == SRC_SPRITE);

  // A sprite pixel drawn on the origin cycle belongs to the new frame's count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      opaque_cnt   <= '0;
      opaque_count <= '0;
    end else if (origin) begin
      opaque_count <= opaque_cnt;
      opaque_cnt   <= draw_sprite ? 13'd1 : '0;
    end else if (draw_sprite && (opaque_cnt != '1)) begin
      opaque_cnt <= opaque_cnt + 13'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Self-checking bench for sprite_layer_renderer: directed steps plus randomized
// pixels, checked against a behavioural sprite/shadow/latency model.
module tb_sprite_layer_renderer;

  localparam int SPR_W  = 64;
  localparam int SPR_H  = 64;
  localparam int FRAMES = 4;
  localparam int SCALE  = 2;   // 2**SCALE_LOG2
  localparam int ROM_N  = SPR_W * SPR_H * FRAMES;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        blank, flip_h, sprite_en;
  logic [1:0]  frame_sel;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [13:0] rom_addr;
  logic [3:0]  rom_q, pal_idx, pal_red, pal_green, pal_blue, red, green, blue;
`ifdef SPRITE_PIXCOUNT_EN
  logic [12:0] opaque_count;
`endif

  logic [3:0]  rom_mem [ROM_N];
  logic [11:0] pal_mem [16];

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_sx, m_sy, m_frame, m_flip, m_en, m_armed;
  int m_addr, m_q;
  int outq[$];
  int m_cnt, m_opq;

  sprite_layer_renderer #(
    .SPR_W(64), .SPR_H(64), .FRAMES(4), .IDX_W(4), .SCALE_LOG2(1), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_sel(frame_sel), .flip_h(flip_h),
    .sprite_en(sprite_en), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue)
`ifdef SPRITE_PIXCOUNT_EN
    , .opaque_count(opaque_count)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];
  assign {pal_red, pal_green, pal_blue} = pal_mem[pal_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_frame = 0; m_flip = 0; m_en = 0; m_armed = 0;
    m_addr = 0; m_q = int'(rom_mem[0]);
    outq.delete();
    outq.push_back(0);
    outq.push_back(0);
    m_cnt = 0; m_opq = 0;
  endtask

  // Presents one pixel (called just after a falling edge), advances one clock, checks.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic b);
    logic [11:0] bgv;
    int dx, dy, lx, ly, addr, res, exp;
    bit hit, vis, origin, drawn;
    bgv = 12'($urandom);
    DrawX = x; DrawY = y; blank = b;
    {bg_red, bg_green, bg_blue} = bgv;
    origin = (x == 10'd0) && (y == 10'd0);
    dx = int'(x) - m_sx;
    dy = int'(y) - m_sy;
    hit = (m_en != 0) && dx >= 0 && dy >= 0 && dx < SPR_W * SCALE && dy < SPR_H * SCALE;
    addr = 0;
    if (hit) begin
      lx = dx / SCALE;
      ly = dy / SCALE;
      if (m_flip != 0) lx = SPR_W - 1 - lx;
      addr = m_frame * SPR_W * SPR_H + ly * SPR_W + lx;
    end
    vis = b && ((m_armed != 0) || origin);
    drawn = 1'b0;
    if (!vis) res = 0;
    else if (hit && rom_mem[addr] != 4'd0) begin
      res = int'(pal_mem[rom_mem[addr]]);
      drawn = 1'b1;
    end else res = int'(bgv);
    outq.push_back(res | (int'(drawn) << 12));
    @(posedge vga_clk);
    m_q = int'(rom_mem[m_addr]);
    if (hit) m_addr = addr;
    if (origin) begin
      m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_frame = int'(frame_sel);
      m_flip = int'(flip_h); m_en = int'(sprite_en); m_armed = 1;
    end
    exp = outq.pop_front();
    if (origin) begin
      m_opq = m_cnt;
      m_cnt = (exp >> 12) & 1;
    end else if (((exp >> 12) & 1) != 0 && m_cnt != 8191) m_cnt++;
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("pal_idx", 32'(pal_idx), 32'(m_q));
    chk("rgb", 32'({red, green, blue}), 32'(exp & 12'hfff));
`ifdef SPRITE_PIXCOUNT_EN
    chk("opaque_count", 32'(opaque_count), 32'(m_opq));
`endif
    @(negedge vga_clk);
  endtask

  task automatic set_params(input int x, input int y, input int f, input int fl, input int en);
    sprite_x = 10'(x); sprite_y = 10'(y); frame_sel = 2'(f);
    flip_h = fl[0]; sprite_en = en[0];
  endtask

  initial begin
    int tmp, xr, yr;
    for (int i = 0; i < ROM_N; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
    rom_mem[0]  = 4'd5;
    rom_mem[65] = 4'd0;

    // reset held with live pixel stimulus
    reset_n = 1'b0;
    set_params(100, 50, 0, 0, 1);
    blank = 1'b1;
    {bg_red, bg_green, bg_blue} = 12'hfff;
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      DrawX = 10'(100 + i); DrawY = 10'd50;
      @(posedge vga_clk); #1;
      chk("reset_rgb", 32'({red, green, blue}), 32'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();

    // frame origin latches placement; then placement/clipping/transparency
    step(10'd0, 10'd0, 1'b1);
    step(10'd100, 10'd50, 1'b1);
    chk("placement_addr0", 32'(rom_addr), 32'd0);
    step(10'd500, 10'd400, 1'b1);
    step(10'd501, 10'd400, 1'b1);
    chk("latency3_colour", 32'({red, green, blue}), 32'(pal_mem[5]));
    step(10'd102, 10'd52, 1'b1);
    chk("placement_addr65", 32'(rom_addr), 32'd65);
    step(10'd99, 10'd50, 1'b1);
    step(10'd227, 10'd177, 1'b1);
    chk("corner_addr", 32'(rom_addr), 32'd4095);
    step(10'd228, 10'd50, 1'b1);
    step(10'd100, 10'd50, 1'b0);   // blanked hit
    step(10'd5, 10'd5, 1'b1);
    step(10'd6, 10'd5, 1'b1);

    // tear-free: mid-frame change has no effect until the next origin
    set_params(300, 50, 0, 0, 1);
    step(10'd120, 10'd200, 1'b1);
    step(10'd120, 10'd60, 1'b1);
    chk("tear_old_pos", 32'(rom_addr), 32'd330);
    step(10'd0, 10'd0, 1'b1);
    step(10'd302, 10'd52, 1'b1);
    chk("tear_new_pos", 32'(rom_addr), 32'd65);

    // flip and frame select
    set_params(100, 50, 2, 1, 1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd100, 10'd50, 1'b1);
    chk("flip_frame_addr", 32'(rom_addr), 32'd8255);
    step(10'd1, 10'd1, 1'b1);
    step(10'd2, 10'd1, 1'b1);

    // asynchronous reset mid-frame clears at once; black until next origin
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("async_rst_addr", 32'(rom_addr), 32'd0);
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
    set_params(100, 50, 1, 0, 1);
    step(10'd110, 10'd60, 1'b1);
    step(10'd111, 10'd60, 1'b1);
    step(10'd112, 10'd60, 1'b1);
    step(10'd0, 10'd0, 1'b1);
    step(10'd110, 10'd60, 1'b1);

    // randomized pixels biased around the sprite, with occasional origins
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)
        set_params($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 3),
                   $urandom_range(0, 1), ($urandom_range(0, 4) != 0) ? 1 : 0);
      if ($urandom_range(0, 199) == 0) begin
        xr = 0; yr = 0;
      end else if ($urandom_range(0, 3) != 0) begin
        tmp = m_sx + int'($urandom_range(0, 140)) - 6; xr = tmp;
        tmp = m_sy + int'($urandom_range(0, 140)) - 6; yr = tmp;
      end else begin
        xr = int'($urandom_range(0, 1023));
        yr = int'($urandom_range(0, 1023));
      end
      step(10'(xr), 10'(yr), ($urandom_range(0, 9) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
